rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port between two requesters:
  - the in-order pipeline writeback (port A);
  - a multi-cycle unit such as mul/div or a late load (port B).
- Keeps a per-register busy scoreboard for long-latency destinations, so decode stalls on RAW/WAW hazards.
- Sits between execute/memory writeback and the RF write inputs (rf_we, wR, wD); drives the decode stall.

Parameters:
- XLEN, 32, data width of write data.
- NREG, 32, number of architectural registers; register 0 is hard-wired zero.
- STARVE_MAX, 4, consecutive cycles port B may be refused before it is force-granted (range 1..15).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- a_valid  in  1  pipeline writeback request.
- a_ready  out  1  port A accepted this cycle.
- a_wr  in  5  port A destination register.
- a_wd  in  XLEN  port A write data.
- b_valid  in  1  multi-cycle unit result request.
- b_ready  out  1  port B accepted this cycle.
- b_wr  in  5  port B destination register.
- b_wd  in  XLEN  port B write data.
- iss_valid  in  1  decode issuing a long-latency op.
- iss_rd  in  5  destination of that op.
- rR1, rR2  in  5 each  source registers of the instruction in decode.
- rd_dec  in  5  destination of the instruction in decode.
- dec_stall  out  1  hazard; decode must hold.
- rf_we  out  1  RF write enable (registered).
- rf_wR  out  5  RF write register (registered).
- rf_wD  out  XLEN  RF write data (registered).

Behaviour:
- Reset: rf_we=0, rf_wR=0, rf_wD=0, scoreboard all clear, starvation counter=0.
- Reset mid-operation discards any pending grant and all busy bits.
- Combinational arbitration each cycle:
  - Default: A has priority. a_ready=1; b_ready=!a_valid.
  - Forced B: when starve_cnt==STARVE_MAX and b_valid, b_ready=1 and a_ready=0.
  - a_ready=0 only in the forced-B cycle; the pipeline must hold port A.
- Grant fires on valid&&ready.
- Next edge after a grant:
  - rf_we=1 and rf_wR/rf_wD come from the granted port. Latency is 1 cycle.
  - With no grant, rf_we=0 and rf_wR/rf_wD hold their values.
- Register 0:
  - A grant to wr==0 is accepted, but rf_we stays 0.
  - Scoreboard bit 0 never sets.
- starve_cnt:
  - Increments while b_valid && !b_ready, saturating at STARVE_MAX.
  - Clears on a B grant or when b_valid=0.
- Scoreboard busy[NREG]:
  - Set on iss_valid && !dec_stall && iss_rd!=0.
  - Cleared on the edge where rf_we=1 for a B-sourced write.
  - Set and clear of the same register in the same cycle: set wins, because a new issue follows the old write.
- dec_stall=1 if any of busy[rR1], busy[rR2] or busy[rd_dec] is set (rd_dec covers WAW), index 0 excluded.
- A B grant targeting a register that is not busy is legal: it writes, and the scoreboard is unaffected.
- Simultaneous a_valid and b_valid with counter below max: A granted, B counter increments.
- No internal buffering: a refused requester holds its request stable until accepted.

Optional Feature:
- Macro WBARB_BYPASS_EN.
- Defined:
  - A source register whose busy bit is being cleared this cycle (rf_we=1, B-sourced, rf_wR matches) does not raise dec_stall.
  - Extra outputs fwd1_hit/fwd2_hit (1 bit) and fwd_data (XLEN=rf_wD) let decode take the value directly.
- Not defined: those ports are absent, and the stall persists until the cycle after the clear.

Decomposition:
- Shared package (rv_pkg):
  - XLEN, NREG, REG_ZERO constant;
  - wb_src_e enum (WB_NONE, WB_A, WB_B), which also tags the registered write for scoreboard clear.
- One natural sub-module: rf_scoreboard, holding the busy vector, set/clear logic and 3-port hazard lookup, plus the bypass compare when enabled.

Test Plan:
- A only: a_valid=1, a_wr=5, a_wd=0x1234 → next cycle rf_we=1, rf_wR=5, rf_wD=0x1234. A write with a_wr=0 → rf_we stays 0.
- Contention: a_valid and b_valid held, STARVE_MAX=4 → A granted for 4 cycles, then b_ready=1 and a_ready=0 in cycle 5. The B write appears next cycle; the counter clears.
- Scoreboard: iss_valid with iss_rd=7, then rR1=7 → dec_stall=1. B writes reg 7 → dec_stall falls the cycle after rf_we=1 (same cycle with WBARB_BYPASS_EN, fwd1_hit=1, fwd_data=b_wd).
- WAW: busy[9] set, rd_dec=9 with sources clear → dec_stall=1. iss_valid during the stall does not set the bit.
- Same-cycle set/clear on reg 3: B write clearing 3 coincides with a new issue to 3 → busy[3] stays 1.
- Reset mid-run: rst=1 with busy bits set and a grant pending → next cycle rf_we=0, all busy clear, dec_stall=0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared register-file writeback types and constants for the writeback arbiter slice.
package rv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam logic [4:0]  REG_ZERO = 5'd0;

  // Tags the registered RF write so the scoreboard knows which writes retire long-latency ops.
  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_A    = 2'd1,
    WB_B    = 2'd2
  } wb_src_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard for long-latency destinations with 3-port hazard lookup.
// Build option WBARB_BYPASS_EN adds same-cycle forwarding of the clearing write.
module rf_scoreboard #(
  parameter int unsigned NREG = 32
`ifdef WBARB_BYPASS_EN
  ,
  parameter int unsigned XLEN = 32
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iss_valid,
  input  logic [4:0]       iss_rd,
  input  logic [4:0]       rR1,
  input  logic [4:0]       rR2,
  input  logic [4:0]       rd_dec,
  input  logic             wb_we,
  input  rv_pkg::wb_src_e  wb_src,
  input  logic [4:0]       wb_wr,
`ifdef WBARB_BYPASS_EN
  input  logic [XLEN-1:0]  wb_wd,
  output logic             fwd1_hit,
  output logic             fwd2_hit,
  output logic [XLEN-1:0]  fwd_data,
`endif
  output logic             dec_stall
);

  import rv_pkg::*;

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;
  logic            clr_en;
  logic            set_en;
  logic            hz1;
  logic            hz2;
  logic            hzd;

  always_comb begin
    clr_en   = wb_we && (wb_src == WB_B);
    clr_mask = '0;
    if (clr_en) begin
      clr_mask[wb_wr] = 1'b1;
    end

    hz1 = (rR1 != REG_ZERO) && busy[rR1];
    hz2 = (rR2 != REG_ZERO) && busy[rR2];
    hzd = (rd_dec != REG_ZERO) && busy[rd_dec];
`ifdef WBARB_BYPASS_EN
    fwd1_hit = clr_en && (wb_wr == rR1) && (rR1 != REG_ZERO);
    fwd2_hit = clr_en && (wb_wr == rR2) && (rR2 != REG_ZERO);
    fwd_data = wb_wd;
    hz1      = hz1 && !fwd1_hit;
    hz2      = hz2 && !fwd2_hit;
`endif
    dec_stall = hz1 || hz2 || hzd;

    set_en   = iss_valid && !dec_stall && (iss_rd != REG_ZERO);
    set_mask = '0;
    if (set_en) begin
      set_mask[iss_rd] = 1'b1;
    end

    // Set is applied after clear: a fresh issue outranks the retiring write.
    busy_nxt    = (busy & ~clr_mask) | set_mask;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the single RF write port between pipeline writeback (A) and a multi-cycle unit (B),
// with starvation-forced B grants. Build option WBARB_BYPASS_EN adds forwarding outputs.
module rf_wb_arbiter #(
  parameter int unsigned XLEN       = rv_pkg::XLEN,
  parameter int unsigned NREG       = rv_pkg::NREG,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [4:0]      a_wr,
  input  logic [XLEN-1:0] a_wd,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [4:0]      b_wr,
  input  logic [XLEN-1:0] b_wd,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  input  logic [4:0]      rR1,
  input  logic [4:0]      rR2,
  input  logic [4:0]      rd_dec,
  output logic            dec_stall,
  output logic            rf_we,
  output logic [4:0]      rf_wR,
  output logic [XLEN-1:0] rf_wD
`ifdef WBARB_BYPASS_EN
  ,
  output logic            fwd1_hit,
  output logic            fwd2_hit,
  output logic [XLEN-1:0] fwd_data
`endif
);

  import rv_pkg::*;

  localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

  logic [3:0]      starve_cnt;
  logic [3:0]      cnt_nxt;
  wb_src_e         wb_src;
  wb_src_e         src_nxt;
  logic [4:0]      wr_nxt;
  logic [XLEN-1:0] wd_nxt;
  logic            forced_b;
  logic            grant_a;
  logic            grant_b;

  always_comb begin
    forced_b = b_valid && (starve_cnt == CNT_MAX);
    a_ready  = !forced_b;
    b_ready  = forced_b || !a_valid;
    grant_a  = a_valid && a_ready;
    grant_b  = b_valid && b_ready;

    // Writes to register 0 are accepted but never reach the RF, so the held address/data stay put.
    src_nxt = WB_NONE;
    wr_nxt  = rf_wR;
    wd_nxt  = rf_wD;
    if (grant_a && (a_wr != REG_ZERO)) begin
      src_nxt = WB_A;
      wr_nxt  = a_wr;
      wd_nxt  = a_wd;
    end else if (grant_b && (b_wr != REG_ZERO)) begin
      src_nxt = WB_B;
      wr_nxt  = b_wr;
      wd_nxt  = b_wd;
    end

    cnt_nxt = starve_cnt;
    if (!b_valid || grant_b) begin
      cnt_nxt = '0;
    end else if (starve_cnt != CNT_MAX) begin
      cnt_nxt = starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_src     <= WB_NONE;
      rf_wR      <= '0;
      rf_wD      <= '0;
      starve_cnt <= '0;
    end else begin
      wb_src     <= src_nxt;
      rf_wR      <= wr_nxt;
      rf_wD      <= wd_nxt;
      starve_cnt <= cnt_nxt;
    end
  end

  assign rf_we = (wb_src != WB_NONE);

  rf_scoreboard #(
    .NREG (NREG)
`ifdef WBARB_BYPASS_EN
    ,
    .XLEN (XLEN)
`endif
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .rR1       (rR1),
    .rR2       (rR2),
    .rd_dec    (rd_dec),
    .wb_we     (rf_we),
    .wb_src    (wb_src),
    .wb_wr     (rf_wR),
`ifdef WBARB_BYPASS_EN
    .wb_wd     (rf_wD),
    .fwd1_hit  (fwd1_hit),
    .fwd2_hit  (fwd2_hit),
    .fwd_data  (fwd_data),
`endif
    .dec_stall (dec_stall)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed table, multi-cycle sequences, randomized model check.
module tb_rf_wb_arbiter;

  localparam int SM = 4;
`ifdef WBARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [4:0]  a_wr, b_wr, iss_rd, rR1, rR2, rd_dec, rf_wR;
  logic [31:0] a_wd, b_wd, rf_wD;
  logic        iss_valid, dec_stall, rf_we;
`ifdef WBARB_BYPASS_EN
  logic        fwd1_hit, fwd2_hit;
  logic [31:0] fwd_data;
`endif

  rf_wb_arbiter #(.XLEN(32), .NREG(32), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_wr(a_wr), .a_wd(a_wd),
    .b_valid(b_valid), .b_ready(b_ready), .b_wr(b_wr), .b_wd(b_wd),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .rR1(rR1), .rR2(rR2), .rd_dec(rd_dec), .dec_stall(dec_stall),
    .rf_we(rf_we), .rf_wR(rf_wR), .rf_wD(rf_wD)
`ifdef WBARB_BYPASS_EN
    , .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd_data(fwd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_valid = 0; a_wr = 0; a_wd = 0;
    b_valid = 0; b_wr = 0; b_wd = 0;
    iss_valid = 0; iss_rd = 0;
    rR1 = 0; rR2 = 0; rd_dec = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  typedef struct {
    logic av; logic [4:0] awr; logic [31:0] awd;
    logic bv; logic [4:0] bwr; logic [31:0] bwd;
    logic iv; logic [4:0] ird;
    logic [4:0] r1, r2, rd;
    logic ear, ebr, est;
    logic ewe, cd; logic [4:0] ewr; logic [31:0] ewd;
  } vec_t;

  vec_t tbl[13];

  // Reference model state
  bit          m_busy[32];
  int          m_cnt;
  bit          m_we, m_srcb;
  logic [4:0]  m_wr;
  logic [31:0] m_wd;

  function automatic bit m_byp(input logic [4:0] r);
    return BYP && m_we && m_srcb && (m_wr == r) && (r != 0);
  endfunction

  initial begin
    logic est4;
    bit ea, eb, es, ga, gb, hold_a, hold_b;

    rst = 1;
    idle();
    tick();
    tick();
    chk("reset_we", rf_we, 0);
    chk("reset_wR", rf_wR, 0);
    chk("reset_wD", rf_wD, 0);
    rst = 0;
    #1;
    chk("reset_a_ready", a_ready, 1);
    chk("reset_b_ready", b_ready, 1);
    chk("reset_stall", dec_stall, 0);

    est4 = BYP ? 1'b0 : 1'b1;
    //            av awr awd           bv bwr bwd         iv ird r1 r2 rd  ear ebr est   ewe cd ewr wd
    tbl[0]  = '{1, 5, 32'h1234,     0, 0, 0,           0, 0,  0, 0, 0,  1, 0, 0,    1, 1, 5, 32'h1234};
    tbl[1]  = '{1, 0, 32'hdead,     0, 0, 0,           0, 0,  0, 0, 0,  1, 0, 0,    0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0,            0, 0, 0,           1, 7,  0, 0, 0,  1, 1, 0,    0, 1, 5, 32'h1234};
    tbl[3]  = '{0, 0, 0,            1, 7, 32'h77,      0, 0,  7, 0, 0,  1, 1, 1,    1, 1, 7, 32'h77};
    tbl[4]  = '{0, 0, 0,            0, 0, 0,           0, 0,  7, 0, 0,  1, 1, est4, 0, 1, 7, 32'h77};
    tbl[5]  = '{0, 0, 0,            0, 0, 0,           0, 0,  7, 0, 0,  1, 1, 0,    0, 1, 7, 32'h77};
    tbl[6]  = '{0, 0, 0,            0, 0, 0,           1, 9,  0, 0, 0,  1, 1, 0,    0, 1, 7, 32'h77};
    tbl[7]  = '{0, 0, 0,            0, 0, 0,           1, 12, 0, 0, 9,  1, 1, 1,    0, 1, 7, 32'h77};
    tbl[8]  = '{0, 0, 0,            0, 0, 0,           0, 0,  0, 12, 0, 1, 1, 0,    0, 1, 7, 32'h77};
    tbl[9]  = '{0, 0, 0,            0, 0, 0,           1, 3,  0, 0, 0,  1, 1, 0,    0, 1, 7, 32'h77};
    tbl[10] = '{0, 0, 0,            1, 3, 32'h33,      0, 0,  0, 0, 0,  1, 1, 0,    1, 1, 3, 32'h33};
    tbl[11] = '{0, 0, 0,            0, 0, 0,           1, 3,  0, 0, 0,  1, 1, 0,    0, 1, 3, 32'h33};
    tbl[12] = '{0, 0, 0,            0, 0, 0,           0, 0,  3, 0, 0,  1, 1, 1,    0, 1, 3, 32'h33};

    for (int i = 0; i < 13; i++) begin
      a_valid = tbl[i].av; a_wr = tbl[i].awr; a_wd = tbl[i].awd;
      b_valid = tbl[i].bv; b_wr = tbl[i].bwr; b_wd = tbl[i].bwd;
      iss_valid = tbl[i].iv; iss_rd = tbl[i].ird;
      rR1 = tbl[i].r1; rR2 = tbl[i].r2; rd_dec = tbl[i].rd;
      #1;
      chk($sformatf("tbl%0d_a_ready", i), a_ready, tbl[i].ear);
      chk($sformatf("tbl%0d_b_ready", i), b_ready, tbl[i].ebr);
      chk($sformatf("tbl%0d_stall", i), dec_stall, tbl[i].est);
`ifdef WBARB_BYPASS_EN
      if (i == 4) begin
        chk("tbl4_fwd1_hit", fwd1_hit, 1);
        chk("tbl4_fwd_data", fwd_data, 32'h77);
      end
`endif
      tick();
      chk($sformatf("tbl%0d_we", i), rf_we, tbl[i].ewe);
      if (tbl[i].cd) begin
        chk($sformatf("tbl%0d_wR", i), rf_wR, tbl[i].ewr);
        chk($sformatf("tbl%0d_wD", i), rf_wD, tbl[i].ewd);
      end
    end

    // Reset while a grant is pending and registers are busy
    idle();
    iss_valid = 1; iss_rd = 7;
    tick();
    idle();
    a_valid = 1; a_wr = 4; a_wd = 32'h4444;
    rst = 1;
    tick();
    rst = 0;
    idle();
    rR1 = 7; rR2 = 3;
    #1;
    chk("rst_mid_we", rf_we, 0);
    chk("rst_mid_wR", rf_wR, 0);
    chk("rst_mid_stall", dec_stall, 0);

    // Contention: A wins SM times, then B is forced
    do_reset();
    a_valid = 1; a_wr = 1; a_wd = 32'haaaa;
    b_valid = 1; b_wr = 2; b_wd = 32'hbbbb;
    for (int k = 0; k < SM; k++) begin
      #1;
      chk($sformatf("cont%0d_a_ready", k), a_ready, 1);
      chk($sformatf("cont%0d_b_ready", k), b_ready, 0);
      tick();
      chk($sformatf("cont%0d_wR", k), rf_wR, 1);
    end
    #1;
    chk("cont_forced_a_ready", a_ready, 0);
    chk("cont_forced_b_ready", b_ready, 1);
    tick();
    chk("cont_b_we", rf_we, 1);
    chk("cont_b_wR", rf_wR, 2);
    chk("cont_b_wD", rf_wD, 32'hbbbb);
    b_wd = 32'hcccc;
    #1;
    chk("cont_cleared_b_ready", b_ready, 0);
    chk("cont_cleared_a_ready", a_ready, 1);

    // Randomized run against the rule-level model
    do_reset();
    for (int r = 0; r < 32; r++) m_busy[r] = 0;
    m_cnt = 0; m_we = 0; m_srcb = 0; m_wr = 0; m_wd = 0;
    hold_a = 0; hold_b = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!hold_a) begin
        a_valid = ($urandom_range(0, 99) < 60);
        a_wr = 5'($urandom_range(0, 7)); a_wd = $urandom;
      end
      if (!hold_b) begin
        b_valid = ($urandom_range(0, 99) < 50);
        b_wr = 5'($urandom_range(0, 7)); b_wd = $urandom;
      end
      iss_valid = ($urandom_range(0, 99) < 30);
      iss_rd = 5'($urandom_range(0, 7));
      rR1 = 5'($urandom_range(0, 7));
      rR2 = 5'($urandom_range(0, 7));
      rd_dec = 5'($urandom_range(0, 7));
      #1;
      eb = (b_valid && m_cnt == SM) || !a_valid;
      ea = !(b_valid && m_cnt == SM);
      es = (rR1 != 0 && m_busy[rR1] && !m_byp(rR1)) ||
           (rR2 != 0 && m_busy[rR2] && !m_byp(rR2)) ||
           (rd_dec != 0 && m_busy[rd_dec]);
      chk("rnd_a_ready", a_ready, ea);
      chk("rnd_b_ready", b_ready, eb);
      chk("rnd_stall", dec_stall, es);
`ifdef WBARB_BYPASS_EN
      chk("rnd_fwd1", fwd1_hit, m_byp(rR1));
      chk("rnd_fwd2", fwd2_hit, m_byp(rR2));
`endif
      ga = a_valid && ea;
      gb = b_valid && eb;
      if (m_we && m_srcb) m_busy[m_wr] = 0;
      if (iss_valid && !es && iss_rd != 0) m_busy[iss_rd] = 1;
      if (!b_valid || gb) m_cnt = 0;
      else if (m_cnt < SM) m_cnt++;
      if (ga && a_wr != 0) begin
        m_we = 1; m_srcb = 0; m_wr = a_wr; m_wd = a_wd;
      end else if (gb && b_wr != 0) begin
        m_we = 1; m_srcb = 1; m_wr = b_wr; m_wd = b_wd;
      end else begin
        m_we = 0;
      end
      hold_a = a_valid && !ga;
      hold_b = b_valid && !gb;
      tick();
      chk("rnd_we", rf_we, m_we);
      if (m_we) begin
        chk("rnd_wR", rf_wR, m_wr);
        chk("rnd_wD", rf_wD, m_wd);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
